// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM state
// encodings, requester port indices, default widths and a one-hot helper.
package dmem_arb_pkg;

   localparam int unsigned DBITS_DEF        = 32;
   localparam int unsigned DMEMADDRBITS_DEF = 13;
   localparam int unsigned DMEMWORDBITS_DEF = 2;

   localparam logic P_CPU = 1'b0;
   localparam logic P_AUX = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCESS  = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   function automatic logic [1:0] onehot2(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester/memory bundle for dmem_arbiter. The slave modport is the
// arbiter's view; the master modport is the view of the requesters plus
// the memory returning read data.
interface dmem_arbiter_if
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DBITS        = DBITS_DEF,
   parameter int unsigned DMEMADDRBITS = DMEMADDRBITS_DEF,
   parameter int unsigned DMEMWORDBITS = DMEMWORDBITS_DEF
);

   logic [1:0]                           req;
   logic [1:0]                           we;
   logic [DBITS-1:0]                     addr0;
   logic [DBITS-1:0]                     addr1;
   logic [DBITS-1:0]                     wdata0;
   logic [DBITS-1:0]                     wdata1;
   logic [1:0]                           gnt;
   logic [1:0]                           ack;
   logic [DBITS-1:0]                     rdata;
   logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_addr;
   logic                                 mem_we;
   logic [DBITS-1:0]                     mem_wdata;
   logic [DBITS-1:0]                     mem_rdata;

   modport slave (
      input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
      output gnt, ack, rdata, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  gnt, ack, rdata, mem_addr, mem_we, mem_wdata
   );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-requester winner selection for dmem_arbiter.
// Default: round-robin, the port that did not win last time takes a tie.
// Build option DMEM_ARB_FIXED_PRIO_EN: port 0 always wins contention and
// the last-winner input is ignored (port 1 may starve).
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner,
   output logic       valid
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
   logic unused_last;
   assign unused_last = last;

   // Fixed priority: port 0 first, port 1 only when port 0 is quiet.
   always_comb begin
      valid  = |req;
      winner = req[P_CPU] ? P_CPU : P_AUX;
   end
`else
   // Round-robin: a lone requester wins, a tie goes to the port != last.
   always_comb begin
      valid  = |req;
      winner = P_CPU;
      case (req)
         2'b01:   winner = P_CPU;
         2'b10:   winner = P_AUX;
         2'b11:   winner = ~last;
         default: winner = P_CPU;
      endcase
   end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for the single-ported synchronous dmem.
// Port 0 is the CPU, port 1 the DMA/debug loader. One transaction at a time
// walks IDLE -> ACCESS -> CAPTURE -> DONE; read data returns with a
// one-cycle ack pulse to the owner.
// Build option: DMEM_ARB_FIXED_PRIO_EN (see rr_pick2) selects fixed priority.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DBITS        = DBITS_DEF,
   parameter int unsigned DMEMADDRBITS = DMEMADDRBITS_DEF,
   parameter int unsigned DMEMWORDBITS = DMEMWORDBITS_DEF
) (
   input logic           clk,
   input logic           reset,
   dmem_arbiter_if.slave bus
);

   state_t           state;
   logic             owner;
   logic             last;

   logic             pick_win;
   logic             pick_valid;
   logic             win_we;
   logic [DBITS-1:0] win_addr;
   logic [DBITS-1:0] win_wdata;

   // Upper address bits alias and the byte offset is ignored by design.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{win_addr[DBITS-1:DMEMADDRBITS],
                               win_addr[DMEMWORDBITS-1:0]};

   rr_pick2 u_pick (
      .req    (bus.req),
      .last   (last),
      .winner (pick_win),
      .valid  (pick_valid)
   );

   // Steer the winning requester's command onto the latch inputs.
   always_comb begin
      win_we    = bus.we[pick_win];
      win_addr  = pick_win ? bus.addr1  : bus.addr0;
      win_wdata = pick_win ? bus.wdata1 : bus.wdata0;
   end

   // Transaction sequencer; every bus output is registered here so that
   // gnt/mem_* are already valid during the first cycle of S_ACCESS.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         owner         <= P_CPU;
         last          <= P_AUX;
         bus.gnt       <= '0;
         bus.ack       <= '0;
         bus.rdata     <= '0;
         bus.mem_addr  <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_wdata <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               bus.gnt    <= '0;
               bus.ack    <= '0;
               bus.mem_we <= 1'b0;
               if (pick_valid) begin
                  owner         <= pick_win;
                  last          <= pick_win;
                  bus.gnt       <= onehot2(pick_win);
                  bus.mem_addr  <= win_addr[DMEMADDRBITS-1:DMEMWORDBITS];
                  bus.mem_we    <= win_we;
                  bus.mem_wdata <= win_wdata;
                  state         <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               bus.mem_we <= 1'b0;
               state      <= S_CAPTURE;
            end
            S_CAPTURE: begin
               bus.rdata <= bus.mem_rdata;
               bus.ack   <= onehot2(owner);
               state     <= S_DONE;
            end
            S_DONE: begin
               bus.ack <= '0;
               bus.gnt <= '0;
               state   <= S_IDLE;
            end
            default: begin
               bus.gnt    <= '0;
               bus.ack    <= '0;
               bus.mem_we <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table of single transactions
// plus hand sequences for withdrawal, reset mid-write and contention.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.DBITS(32), .DMEMADDRBITS(13), .DMEMWORDBITS(2)) bus ();

   dmem_arbiter #(.DBITS(32), .DMEMADDRBITS(13), .DMEMWORDBITS(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int ack_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous dmem model with 1-cycle read latency and a backdoor port.
   logic [31:0] mem [0:2047];
   logic        bd_we = 1'b0;
   logic [10:0] bd_addr = '0;
   logic [31:0] bd_data = '0;
   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   typedef struct {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [10:0] ema;
      logic [31:0] erd;
   } vec_t;
   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [10:0] a, input logic [31:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      tick();
      bd_we = 1'b0;
   endtask

   function automatic logic [1:0] oh(input logic p);
      return p ? 2'b10 : 2'b01;
   endfunction

   task automatic wait_gnt(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (bus.gnt != 2'b00) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL %s.gnt_timeout: got gnt=%b expected nonzero", name, bus.gnt);
      end
   endtask

   // Follows one granted transaction; returns positioned in the ack cycle.
   task automatic run_one(input string name, input logic p, input logic w,
                          input logic [31:0] wd, input logic [10:0] ema,
                          input logic [31:0] erd);
      bit ok;
      wait_gnt(name, ok);
      if (!ok) return;
      chk({name, ".acc_gnt"}, 32'(bus.gnt), 32'(oh(p)));
      chk({name, ".acc_maddr"}, 32'(bus.mem_addr), 32'(ema));
      chk({name, ".acc_we"}, 32'(bus.mem_we), 32'(w));
      chk({name, ".acc_ack"}, 32'(bus.ack), 32'd0);
      if (w) chk({name, ".acc_wdata"}, bus.mem_wdata, wd);
      tick();
      chk({name, ".cap_gnt"}, 32'(bus.gnt), 32'(oh(p)));
      chk({name, ".cap_we"}, 32'(bus.mem_we), 32'd0);
      chk({name, ".cap_maddr"}, 32'(bus.mem_addr), 32'(ema));
      chk({name, ".cap_ack"}, 32'(bus.ack), 32'd0);
      tick();
      chk({name, ".done_ack"}, 32'(bus.ack), 32'(oh(p)));
      chk({name, ".done_gnt"}, 32'(bus.gnt), 32'(oh(p)));
      if (!w) chk({name, ".rdata"}, bus.rdata, erd);
      ack_cyc = cyc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] exp_tie [4];
      int prev_ack;
      bit ok;

      bus.req = '0; bus.we = '0;
      bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

      vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         11'd4,    32'hDEADBEEF};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_0024, 32'h12345678,  11'd9,    32'h0};
      vecs[2] = '{1'b0, 1'b0, 32'h0000_0024, 32'h0,         11'd9,    32'h12345678};
      vecs[3] = '{1'b1, 1'b0, 32'h0000_2010, 32'h0,         11'd4,    32'hDEADBEEF};
      vecs[4] = '{1'b1, 1'b0, 32'hFFFF_E027, 32'h0,         11'd9,    32'h12345678};
      vecs[5] = '{1'b0, 1'b1, 32'h0000_0403, 32'h0BADF00D,  11'd256,  32'h0};
      vecs[6] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         11'd256,  32'h0BADF00D};
      vecs[7] = '{1'b0, 1'b0, 32'h0000_2004, 32'h0,         11'd1,    32'hA5A50001};
      vecs[8] = '{1'b0, 1'b1, 32'h0000_1FFC, 32'h77778888,  11'd2047, 32'h0};
      vecs[9] = '{1'b1, 1'b0, 32'h0000_3FFC, 32'h0,         11'd2047, 32'h77778888};

      // Reset state
      tick();
      tick();
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_ack", 32'(bus.ack), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_state", 32'(dut.state), 32'(S_IDLE));
      chk("rst_last", 32'(dut.last), 32'd1);

      poke(11'd4, 32'hDEADBEEF);
      poke(11'd1, 32'hA5A50001);
      poke(11'd2, 32'h11112222);
      reset = 1'b0;
      tick();

      // Table of single-requester transactions
      foreach (vecs[i]) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         bus.we[vecs[i].port] = vecs[i].we;
         if (vecs[i].port) begin
            bus.addr1 = vecs[i].addr; bus.wdata1 = vecs[i].wdata;
         end else begin
            bus.addr0 = vecs[i].addr; bus.wdata0 = vecs[i].wdata;
         end
         bus.req[vecs[i].port] = 1'b1;
         run_one(nm, vecs[i].port, vecs[i].we, vecs[i].wdata, vecs[i].ema, vecs[i].erd);
         bus.req[vecs[i].port] = 1'b0;
         tick();
         chk({nm, ".idle_gnt"}, 32'(bus.gnt), 32'd0);
         chk({nm, ".idle_ack"}, 32'(bus.ack), 32'd0);
      end

      // Withdraw after grant still completes; a req raised and dropped while busy is never seen
      bus.we = '0;
      bus.addr0 = 32'h0000_2004;
      bus.req[0] = 1'b1;
      wait_gnt("wd", ok);
      if (ok) begin
         chk("wd.acc_gnt", 32'(bus.gnt), 32'b01);
         chk("wd.acc_maddr", 32'(bus.mem_addr), 32'd1);
         bus.req[0] = 1'b0;
         tick();
         bus.addr1 = 32'h0000_0010;
         bus.req[1] = 1'b1;
         chk("wd.cap_gnt", 32'(bus.gnt), 32'b01);
         tick();
         chk("wd.done_ack", 32'(bus.ack), 32'b01);
         chk("wd.rdata", bus.rdata, 32'hA5A50001);
         bus.req[1] = 1'b0;
         for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("wd.quiet%0d_gnt", k), 32'(bus.gnt), 32'd0);
            chk($sformatf("wd.quiet%0d_ack", k), 32'(bus.ack), 32'd0);
         end
      end

      // Reset while a write sits in S_ACCESS
      bus.we[0] = 1'b1;
      bus.addr0 = 32'h0000_0008;
      bus.wdata0 = 32'hCAFE0000;
      bus.req[0] = 1'b1;
      wait_gnt("rstw", ok);
      chk("rstw.acc_we", 32'(bus.mem_we), 32'd1);
      chk("rstw.acc_maddr", 32'(bus.mem_addr), 32'd2);
      #2 reset = 1'b1;
      #1;
      chk("rstw.gnt", 32'(bus.gnt), 32'd0);
      chk("rstw.ack", 32'(bus.ack), 32'd0);
      chk("rstw.mem_we", 32'(bus.mem_we), 32'd0);
      chk("rstw.state", 32'(dut.state), 32'(S_IDLE));
      bus.req = '0;
      bus.we = '0;
      tick();
      reset = 1'b0;
      tick();
      tick();
      chk("rstw.word2", mem[2], 32'h11112222);

      // Contention: both hold req from a freshly reset pointer
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp_tie = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
      exp_tie = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
      bus.addr0 = 32'h0000_0010;
      bus.addr1 = 32'h0000_0024;
      bus.req = 2'b11;
      prev_ack = 0;
      for (int k = 0; k < 4; k++) begin
         logic p;
         p = exp_tie[k][0];
         run_one($sformatf("tie%0d", k), p, 1'b0, 32'h0,
                 p ? 11'd9 : 11'd4, p ? 32'h12345678 : 32'hDEADBEEF);
         if (k > 0) chk($sformatf("tie%0d.ack_spacing", k), 32'(ack_cyc - prev_ack), 32'd4);
         prev_ack = ack_cyc;
         if (k == 3) bus.req[0] = 1'b0;
      end
      run_one("tie_p1", 1'b1, 1'b0, 32'h0, 11'd9, 32'h12345678);
      chk("tie_p1.ack_spacing", 32'(ack_cyc - prev_ack), 32'd4);
      bus.req[1] = 1'b0;
      tick();
      chk("tie_end.gnt", 32'(bus.gnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
